// File: rtl/nes_pkg.sv
// Shared definitions for the iNES cartridge loader.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package nes_pkg;

    // First four header bytes of every iNES image: "NES" followed by 0x1A
    localparam logic [31:0] INES_MAGIC = 32'h4E45531A;
    localparam int          HDR_LEN    = 16;

    // Only single-unit images are supported: one 16 KB PRG bank, one 8 KB CHR bank
    localparam logic [7:0]  PRG_UNITS  = 8'h01;
    localparam logic [7:0]  CHR_UNITS  = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PRG,
        ST_CHR,
        ST_ERR
    } ld_state_t;

    // Magic byte by header position, most significant byte first on the wire
    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = INES_MAGIC[31:24];
            2'd1:    b = INES_MAGIC[23:16];
            2'd2:    b = INES_MAGIC[15:8];
            default: b = INES_MAGIC[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// 2-flop synchronizer followed by a registered rising-edge detector.
// Latency: input rise to one-cycle pulse in 3 clk edges.
// Backpressure: none; a level held high yields exactly one pulse.
module sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic pulse
);

    // sh[1:0] are the synchronizer flops; sh[2] holds the previous synchronized level
    logic [2:0] sh;

    // Shift the asynchronous level in and register the rise as a single pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh    <= 3'b000;
            pulse <= 1'b0;
        end else begin
            sh    <= {sh[1:0], din};
            pulse <= sh[1] & ~sh[2];
        end
    end

endmodule

// File: rtl/nes_loader.sv
// Parses an iNES image from the UART and streams PRG/CHR bytes into the ROM write ports.
// Latency: rx_ready rise to *_wren in 4 clk edges; address advances on the cycle after wren.
// Backpressure: none; every received byte is consumed, stalls are caught by an idle timeout.
module nes_loader #(
    parameter int PRG_AW  = 14,
    parameter int CHR_AW  = 13,
    parameter int TIMEOUT = 25_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_byte,
    input  logic              rx_ready,
    output logic [PRG_AW-1:0] prg_addr,
    output logic [7:0]        prg_data,
    output logic              prg_wren,
    output logic [CHR_AW-1:0] chr_addr,
    output logic [7:0]        chr_data,
    output logic              chr_wren,
    output logic              sys_reset,
    output logic              mirror_v,
    output logic              busy,
    output logic              done,
    output logic              error
);
    import nes_pkg::*;

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [3:0]    HDR_LAST = 4'(HDR_LEN - 1);

    logic              strobe;
    ld_state_t         state_q, state_d;
    logic [3:0]        hdr_cnt_q, hdr_cnt_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic [PRG_AW-1:0] prg_addr_d;
    logic [7:0]        prg_data_d;
    logic              prg_wren_d;
    logic [CHR_AW-1:0] chr_addr_d;
    logic [7:0]        chr_data_d;
    logic              chr_wren_d;
    logic              mirror_d;
    logic              done_d;
    logic              error_d;
    logic              hdr_bad;
    logic              timeout;

    sync_edge u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (rx_ready),
        .pulse   (strobe)
    );

    // A strobe in the same cycle always wins over an expiring counter
    assign timeout   = (idle_q == TO_LAST) && !strobe;
    assign sys_reset = (state_q != ST_IDLE);
    assign busy      = (state_q == ST_HDR) || (state_q == ST_PRG) || (state_q == ST_CHR);

    // Next-state, datapath and strobe generation; writes happen on the strobe,
    // address/state bookkeeping on the following cycle while wren is high
    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        idle_d     = strobe ? '0 : idle_q + TW'(1);
        prg_addr_d = prg_addr;
        prg_data_d = prg_data;
        prg_wren_d = 1'b0;
        chr_addr_d = chr_addr;
        chr_data_d = chr_data;
        chr_wren_d = 1'b0;
        mirror_d   = mirror_v;
        done_d     = 1'b0;
        error_d    = error;
        hdr_bad    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idle_d = '0;
                if (strobe) begin
                    error_d   = 1'b0;
                    hdr_cnt_d = 4'd1;
                    if (rx_byte == magic_byte(2'd0)) begin
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                if (strobe) begin
                    hdr_cnt_d = hdr_cnt_q + 4'd1;
                    case (hdr_cnt_q)
                        4'd1, 4'd2, 4'd3: hdr_bad = (rx_byte != magic_byte(hdr_cnt_q[1:0]));
                        4'd4:             hdr_bad = (rx_byte != PRG_UNITS);
                        4'd5:             hdr_bad = (rx_byte != CHR_UNITS);
                        4'd6:             mirror_d = rx_byte[0];
                        default:          hdr_bad = 1'b0;
                    endcase
                    if (hdr_bad) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end else if (hdr_cnt_q == HDR_LAST) begin
                        state_d    = ST_PRG;
                        prg_addr_d = '0;
                    end
                end else if (timeout) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                    idle_d  = '0;
                end
            end
            ST_PRG: begin
                if (strobe) begin
                    prg_wren_d = 1'b1;
                    prg_data_d = rx_byte;
                end else if (prg_wren) begin
                    prg_addr_d = prg_addr + PRG_AW'(1);
                    if (prg_addr == '1) begin
                        state_d    = ST_CHR;
                        chr_addr_d = '0;
                    end
                end else if (timeout) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                    idle_d  = '0;
                end
            end
            ST_CHR: begin
                if (strobe) begin
                    chr_wren_d = 1'b1;
                    chr_data_d = rx_byte;
                end else if (chr_wren) begin
                    chr_addr_d = chr_addr + CHR_AW'(1);
                    if (chr_addr == '1) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                    idle_d  = '0;
                end
            end
            ST_ERR: begin
                error_d = 1'b1;
                if (timeout) begin
                    state_d = ST_IDLE;
                    idle_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset returns to IDLE without touching memory
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            hdr_cnt_q <= 4'd0;
            idle_q    <= '0;
            prg_addr  <= '0;
            prg_data  <= 8'h00;
            prg_wren  <= 1'b0;
            chr_addr  <= '0;
            chr_data  <= 8'h00;
            chr_wren  <= 1'b0;
            mirror_v  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            idle_q    <= idle_d;
            prg_addr  <= prg_addr_d;
            prg_data  <= prg_data_d;
            prg_wren  <= prg_wren_d;
            chr_addr  <= chr_addr_d;
            chr_data  <= chr_data_d;
            chr_wren  <= chr_wren_d;
            mirror_v  <= mirror_d;
            done      <= done_d;
            error     <= error_d;
        end
    end

endmodule
